mult_rr_arbiter: RTL
====================

# mult_rr_arbiter

Round-robin arbiter and sequencer that shares one `UNS_3X3_MULT` unsigned multiplier between `N_REQ` requesters. It sits between the requesting blocks and the multiplier's `GO`/`READY` handshake. For each job it captures the winner's operands, issues a one-cycle `GO`, tracks the multiplier through busy and done, and returns the product tagged with the requester ID. A watchdog converts a hung multiplier into an error response.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `MULTIPLICAND_WIDTH`, 3, operand A width.
- `MULTIPLIER_WIDTH`, 3, operand B width.
- `PRODUCT_WIDTH`, 6, product width (= A width + B width).
- `WATCHDOG_CYCLES`, 31, maximum cycles spent in either wait state before abort.
- `ID_W`, `$clog2(N_REQ)`, requester ID width (derived).

Ports:
- `SYS_CLOCK` in 1: single clock, rising edge.
- `FSM_SRESET` in 1: reset, synchronous, active-high.
- `REQ` in `N_REQ`: request bits, level; bit i belongs to requester i.
- `REQ_A` in `N_REQ*MULTIPLICAND_WIDTH`: packed operand A; slice i belongs to requester i.
- `REQ_B` in `N_REQ*MULTIPLIER_WIDTH`: packed operand B; slice i belongs to requester i.
- `GNT` out `N_REQ`: one-hot, one-cycle pulse; operands of the granted requester are captured.
- `RSP_VALID` out 1: one-cycle response pulse.
- `RSP_ID` out `ID_W`: requester the response belongs to.
- `RSP_Y` out `PRODUCT_WIDTH`: product.
- `RSP_ERR` out 1: watchdog abort; `RSP_Y` = 0 when set.
- `BUSY` out 1: high in every state except IDLE.
- `MULT_GO` out 1: start pulse to the multiplier.
- `MULT_A` out `MULTIPLICAND_WIDTH`: operand A to the multiplier.
- `MULT_B` out `MULTIPLIER_WIDTH`: operand B to the multiplier.
- `MULT_READY` in 1: multiplier idle; high also means its product is valid.
- `MULT_Y` in `PRODUCT_WIDTH`: multiplier product register.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE:**
  - Arbitrates when `|REQ` and `MULT_READY` are both high.
  - Search starts at pointer `PRIO` and goes upward, wrapping at `N_REQ-1`.
  - The winner's operands are latched into `MULT_A`/`MULT_B`, the winner's ID into `RSP_ID`, and `GNT[winner]` is registered.
  - Next state is ISSUE.
  - No grant while `MULT_READY`=0.
- **ISSUE:** `MULT_GO`=1 for exactly this cycle. Next state is WAIT_BUSY.
- **WAIT_BUSY:**
  - Waits for `MULT_READY`=0, i.e. the multiplier has accepted `GO`; then WAIT_DONE.
  - Watchdog expiry goes to RESP with error.
- **WAIT_DONE:**
  - On `MULT_READY`=1, captures `MULT_Y` into `RSP_Y`; then RESP.
  - Watchdog expiry goes to RESP with error.
- **RESP:**
  - `RSP_VALID`=1 with `RSP_ID`/`RSP_Y`/`RSP_ERR` stable.
  - `PRIO` becomes winner+1 mod `N_REQ`.
  - Next state is IDLE.
- **Watchdog counter:**
  - Cleared on entry to WAIT_BUSY and on entry to WAIT_DONE.
  - Increments each cycle spent in a wait state.
  - Expires when it reaches `WATCHDOG_CYCLES`.
  - On error: `RSP_ERR`=1, `RSP_Y`=0, and `PRIO` still advances.
- **Operand stability:** `MULT_A`/`MULT_B` hold from the ISSUE cycle until IDLE is re-entered.
- **Requester handshake:**
  - A requester holds `REQ`/operands until it sees `GNT`.
  - `REQ` still high in the cycle after `GNT` counts as a new request.
- **No backpressure:** `RSP_VALID` is a pulse and cannot be stalled.
- **Arithmetic:** no arithmetic is done in this block; `RSP_Y` = `MULT_Y` bit-for-bit. The maximum product is 7×7 = 49 and fits 6 bits.
- **Request changes:** a `REQ` change while BUSY has no effect until IDLE.
- **One job at a time:** at most one job is in flight.

## Timing
- **Reset:** on `FSM_SRESET` at a clock edge:
  - State goes to IDLE and `PRIO` to 0.
  - All outputs go to 0: `GNT`, `RSP_VALID`, `RSP_ID`, `RSP_Y`, `RSP_ERR`, `BUSY`, `MULT_GO`, `MULT_A`, `MULT_B`.
- **Reset mid-operation:** the in-flight job is dropped silently and no response is issued. This block does not reset the multiplier; IDLE waits for `MULT_READY` before the next grant.
- **Grant latency:** `REQ` sampled high in IDLE at edge k gives `GNT` and ISSUE in cycle k+1, and `MULT_GO` in cycle k+1.
- **Response latency:** `RSP_VALID` = 1 cycle after `MULT_READY` is sampled high in WAIT_DONE.
- **Minimum turnaround:** GNT to RSP_VALID ≥ 4 cycles. A new grant is possible in the cycle after RESP.
- **Reset priority:** `FSM_SRESET` overrides all other inputs in the same cycle.
- **Output registration:** all outputs are registered except `BUSY` and `MULT_GO`, which are Moore decodes of state.

## Test plan
- **Single request:** after reset, `REQ`=0001, A0=7, B0=2 → `GNT`=0001 for one cycle, `MULT_GO` for one cycle, then `RSP_VALID` with `RSP_ID`=0, `RSP_Y`=14, `RSP_ERR`=0.
- **All four requesting:** `REQ`=1111 held, requester i has A=i+1, B=3, each drops `REQ` after its `GNT` → grants in order 0,1,2,3; `RSP_Y` = 3,6,9,12 with matching `RSP_ID`.
- **Fairness:** `REQ`=1010 held permanently from reset → grant order 1,3,1,3; `GNT[0]` and `GNT[2]` never assert.
- **Multiplier busy at arbitration:** `MULT_READY`=0 while `REQ`=0100 → no `GNT`, `BUSY`=0; raise `MULT_READY` → `GNT`=0100 on the next cycle.
- **Watchdog:** multiplier model drops READY after GO and never raises it → exactly `WATCHDOG_CYCLES` cycles in WAIT_DONE, then `RSP_VALID`=1, `RSP_ERR`=1, `RSP_Y`=0, `PRIO` advanced.
- **Reset mid-operation:** `FSM_SRESET` pulsed for one cycle during WAIT_DONE of requester 2 → next cycle all outputs 0, no `RSP_VALID` for requester 2; a following `REQ`=1111 grants requester 0 first.

Source files
------------

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter and sequencer that shares one unsigned multiplier
// between N_REQ requesters. One job is in flight at a time: the winner's
// operands are captured, GO is pulsed, the multiplier's READY handshake is
// tracked through busy/done, and the product is returned tagged with the
// requester ID. A watchdog turns a hung multiplier into an error response.
module mult_rr_arbiter #(
   parameter int N_REQ              = 4,
   parameter int MULTIPLICAND_WIDTH = 3,
   parameter int MULTIPLIER_WIDTH   = 3,
   parameter int PRODUCT_WIDTH      = 6,
   parameter int WATCHDOG_CYCLES    = 31,
   parameter int ID_W               = $clog2(N_REQ)
) (
   input  logic                                   SYS_CLOCK,
   input  logic                                   FSM_SRESET,
   input  logic [N_REQ-1:0]                       REQ,
   input  logic [N_REQ*MULTIPLICAND_WIDTH-1:0]    REQ_A,
   input  logic [N_REQ*MULTIPLIER_WIDTH-1:0]      REQ_B,
   output logic [N_REQ-1:0]                       GNT,
   output logic                                   RSP_VALID,
   output logic [ID_W-1:0]                        RSP_ID,
   output logic [PRODUCT_WIDTH-1:0]               RSP_Y,
   output logic                                   RSP_ERR,
   output logic                                   BUSY,
   output logic                                   MULT_GO,
   output logic [MULTIPLICAND_WIDTH-1:0]          MULT_A,
   output logic [MULTIPLIER_WIDTH-1:0]            MULT_B,
   input  logic                                   MULT_READY,
   input  logic [PRODUCT_WIDTH-1:0]               MULT_Y
);

   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   state_t                        state_q, state_d;
   logic [ID_W-1:0]               prio_q, prio_d;
   logic [N_REQ-1:0]              gnt_q, gnt_d;
   logic                          rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]               rsp_id_q, rsp_id_d;
   logic [PRODUCT_WIDTH-1:0]      rsp_y_q, rsp_y_d;
   logic                          rsp_err_q, rsp_err_d;
   logic [MULTIPLICAND_WIDTH-1:0] mult_a_q, mult_a_d;
   logic [MULTIPLIER_WIDTH-1:0]   mult_b_q, mult_b_d;
   logic [WD_W-1:0]               wd_q, wd_d;

   logic                          win_found;
   logic [ID_W-1:0]               win_id;
   logic [ID_W:0]                 cand;
   logic                          wd_expired;

   // The watchdog counts from 0, so the last permitted wait cycle is WATCHDOG_CYCLES-1.
   assign wd_expired = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

   // Round-robin search: first requester at or above the pointer, wrapping past N_REQ-1.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = {1'b0, prio_q} + (ID_W+1)'(off);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!win_found && REQ[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = cand[ID_W-1:0];
         end
      end
   end

   // Next-state and registered-output logic for the job sequencer.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      gnt_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      rsp_err_d   = rsp_err_q;
      mult_a_d    = mult_a_q;
      mult_b_d    = mult_b_q;
      wd_d        = wd_q;
      unique case (state_q)
         S_IDLE: begin
            // A READY multiplier is required so a job dropped by reset cannot collide with a new one.
            if (win_found && MULT_READY) begin
               state_d   = S_ISSUE;
               gnt_d     = N_REQ'(1) << win_id;
               rsp_id_d  = win_id;
               rsp_y_d   = '0;
               rsp_err_d = 1'b0;
               mult_a_d  = REQ_A[win_id*MULTIPLICAND_WIDTH +: MULTIPLICAND_WIDTH];
               mult_b_d  = REQ_B[win_id*MULTIPLIER_WIDTH +: MULTIPLIER_WIDTH];
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
            wd_d    = '0;
         end
         S_WAIT_BUSY: begin
            if (!MULT_READY) begin
               state_d = S_WAIT_DONE;
               wd_d    = '0;
            end else if (wd_expired) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_y_d     = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (MULT_READY) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_y_d     = MULT_Y;
            end else if (wd_expired) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_y_d     = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            prio_d  = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight job silently.
   always_ff @(posedge SYS_CLOCK) begin
      if (FSM_SRESET) begin
         state_q     <= S_IDLE;
         prio_q      <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         rsp_err_q   <= 1'b0;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         rsp_err_q   <= rsp_err_d;
         mult_a_q    <= mult_a_d;
         mult_b_q    <= mult_b_d;
         wd_q        <= wd_d;
      end
   end

   assign GNT       = gnt_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ID    = rsp_id_q;
   assign RSP_Y     = rsp_y_q;
   assign RSP_ERR   = rsp_err_q;
   assign MULT_A    = mult_a_q;
   assign MULT_B    = mult_b_q;
   assign BUSY      = (state_q != S_IDLE);
   assign MULT_GO   = (state_q == S_ISSUE);

endmodule
